maxpool_2x2_line: RTL and testbench

Streaming 2x2 stride-2 signed max-pooling stage that sits directly downstream of the `filter_n2_line` convolution layer. It consumes the layer's per-channel output pixels in raster order, buffers one half-width line of horizontal maxima per channel, and emits one pooled pixel per channel for every 2x2 window, at a quarter of the input rate. All channels are pooled in lockstep from a shared column/row sequencer.

---
 rtl/maxpool_2x2_line_pkg.sv | 24 ++
 rtl/maxpool_2x2_line_linebuf.sv | 28 ++
 rtl/maxpool_2x2_line.sv | 136 +++++++++++++
 tb/tb_maxpool_2x2_line.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_2x2_line_pkg.sv
// Shared definitions for the 2x2 max-pooling stage and its upstream filter layer:
// default widths, the signed max helper and the packed-channel slice helper.
package maxpool_2x2_line_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int ADDR_W_DEF = 11;

  // smax works on a 64-bit signed carrier; callers sign-extend in and truncate out.
  localparam int SMAX_W = 64;

  // Signed maximum; on a tie the first operand wins.
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

  // LSB position of channel k in a packed multi-channel bus.
  function automatic int ch_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/maxpool_2x2_line_linebuf.sv
// Simple dual-port line buffer: one write port, one registered read port
// whose data holds until the next read enable.
module pool_linebuf #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  // No reset: every even row rewrites the entries before an odd row reads them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/maxpool_2x2_line.sv
// Streaming 2x2 stride-2 signed max pooling over NCH channels in lockstep,
// with one half-width line of horizontal maxima buffered per channel.
module maxpool_2x2_line
  import maxpool_2x2_line_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NCH    = 2,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [ADDR_W:0]      img_w,
  input  logic                 sof,
  input  logic                 en,
  input  logic [NCH*WIDTH-1:0] in,
  output logic [NCH*WIDTH-1:0] out,
  output logic                 out_valid,
  output logic                 out_eol
);

  logic [ADDR_W:0] col;
  logic            row_odd;
  logic [ADDR_W:0] width_lat;

  logic [ADDR_W:0] cur_col;
  logic            cur_row_odd;
  logic [ADDR_W:0] cur_w;
  logic [ADDR_W:0] w_m1;
  logic            active;
  logic            wr_fire;
  logic            rd_fire;
  logic            out_fire;
  logic            eol_now;

  // A start-of-frame beat overrides the running position and uses the new width.
  always_comb begin
    cur_col     = col;
    cur_row_odd = row_odd;
    cur_w       = width_lat;
    if (sof) begin
      cur_col     = '0;
      cur_row_odd = 1'b0;
      cur_w       = img_w;
    end
  end

  always_comb begin
    w_m1     = cur_w - 1'b1;
    active   = (cur_w >= (ADDR_W+1)'(2));
    wr_fire  = en & active & ~cur_row_odd &  cur_col[0];
    rd_fire  = en & active &  cur_row_odd & ~cur_col[0];
    out_fire = en & active &  cur_row_odd &  cur_col[0];
    eol_now  = (cur_col == w_m1) | ((cur_col == (w_m1 - 1'b1)) & cur_w[0]);
  end

  // Shared column/row sequencer.
  always_ff @(posedge clk) begin
    if (resetn) begin
      col       <= '0;
      row_odd   <= 1'b0;
      width_lat <= '0;
    end else if (en) begin
      width_lat <= cur_w;
      if (cur_col == w_m1) begin
        col     <= '0;
        row_odd <= ~cur_row_odd;
      end else begin
        col     <= cur_col + 1'b1;
        row_odd <= cur_row_odd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      out_valid <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      out_valid <= out_fire;
      out_eol   <= out_fire & eol_now;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [WIDTH-1:0] pix;
    logic signed [WIDTH-1:0] h;
    logic signed [WIDTH-1:0] rd;
    logic signed [WIDTH-1:0] hmax;
    logic signed [WIDTH-1:0] omax;
    logic signed [WIDTH-1:0] o;
    logic [SMAX_W-1:0]       hmax_w;
    logic [SMAX_W-1:0]       omax_w;

    assign pix = in[ch_lsb(k, WIDTH) +: WIDTH];

    always_comb begin
      hmax_w = smax(SMAX_W'(h), SMAX_W'(pix));
      hmax   = hmax_w[WIDTH-1:0];
      omax_w = smax(SMAX_W'(hmax), SMAX_W'(rd));
      omax   = omax_w[WIDTH-1:0];
    end

    // h holds the left pixel of the current horizontal pair.
    always_ff @(posedge clk) begin
      if (resetn) begin
        h <= '0;
      end else if (en && !cur_col[0]) begin
        h <= pix;
      end
    end

    pool_linebuf #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
    ) u_linebuf (
      .clk   (clk),
      .we    (wr_fire),
      .waddr (cur_col[ADDR_W:1]),
      .wdata (hmax),
      .re    (rd_fire),
      .raddr (cur_col[ADDR_W:1]),
      .rdata (rd)
    );

    always_ff @(posedge clk) begin
      if (resetn) begin
        o <= '0;
      end else if (out_fire) begin
        o <= omax;
      end
    end

    assign out[ch_lsb(k, WIDTH) +: WIDTH] = o;
  end

endmodule

// File: tb/tb_maxpool_2x2_line.sv
// Directed bench for maxpool_2x2_line: window table plus multi-cycle frame sequences.
module tb_maxpool_2x2_line;

  localparam int WIDTH  = 16;
  localparam int NCH    = 2;
  localparam int ADDR_W = 11;

  logic                 clk;
  logic                 resetn;
  logic [ADDR_W:0]      img_w;
  logic                 sof;
  logic                 en;
  logic [NCH*WIDTH-1:0] pix_in;
  logic [NCH*WIDTH-1:0] pool_out;
  logic                 out_valid;
  logic                 out_eol;

  int checks = 0;
  int errors = 0;

  // Expected item: {eol, ch1, ch0}
  logic [32:0] exp_q[$];

  typedef struct {
    logic [3:0][15:0] p0;
    logic [3:0][15:0] p1;
    int               e0;
    int               e1;
  } win_t;

  win_t tbl[5];

  maxpool_2x2_line #(
    .WIDTH  (WIDTH),
    .NCH    (NCH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .img_w     (img_w),
    .sof       (sof),
    .en        (en),
    .in        (pix_in),
    .out       (pool_out),
    .out_valid (out_valid),
    .out_eol   (out_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  function automatic logic [32:0] ex(input bit eol, input int a0, input int a1);
    return {eol, 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [31:0] px(input int mode, input int w, input int r, input int c);
    logic signed [15:0] a;
    if (mode == 0) begin
      a = 16'(r * w + c);
      return {-a, a};
    end
    a = (c == 4) ? 16'sd32767 : -16'sd5;
    return {a, a};
  endfunction

  function automatic win_t mk(input int t0, input int t1, input int t2, input int t3,
                              input int u0, input int u1, input int u2, input int u3,
                              input int e0, input int e1);
    win_t v;
    v.p0[0] = 16'(t0); v.p0[1] = 16'(t1); v.p0[2] = 16'(t2); v.p0[3] = 16'(t3);
    v.p1[0] = 16'(u0); v.p1[1] = 16'(u1); v.p1[2] = 16'(u2); v.p1[3] = 16'(u3);
    v.e0 = e0;
    v.e1 = e1;
    return v;
  endfunction

  // One cycle: drive on the falling edge, check the registered result just after the rising edge.
  task automatic beat(input logic s, input logic e, input logic [31:0] p, input bit exp_v);
    logic [32:0] item;
    @(negedge clk);
    sof    = s;
    en     = e;
    pix_in = p;
    @(posedge clk);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
    if (exp_v && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL exp_q: output seen but expected queue empty, got %0h", pool_out);
      end else begin
        item = exp_q.pop_front();
        chk("out", {32'd0, pool_out}, {32'd0, item[31:0]});
        chk("out_eol", {63'd0, out_eol}, {63'd0, item[32]});
      end
    end
  endtask

  task automatic idle();
    beat(1'b0, 1'b0, $urandom, 1'b0);
  endtask

  task automatic frame(input int w, input int rows, input int mode, input bit toggle);
    img_w = (ADDR_W+1)'(w);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < w; c++) begin
        beat((r == 0 && c == 0), 1'b1, px(mode, w, r, c), (r % 2 == 1) && (c % 2 == 1));
        if (toggle) idle();
      end
    end
  endtask

  initial begin
    resetn = 1'b1;
    sof    = 1'b0;
    en     = 1'b0;
    pix_in = '0;
    img_w  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {32'd0, pool_out}, 64'd0);
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_eol", {63'd0, out_eol}, 64'd0);
    @(negedge clk);
    resetn = 1'b0;

    // 4x4 raster frame, continuous then with en toggling
    exp_q.push_back(ex(0, 5, 0));
    exp_q.push_back(ex(1, 7, -2));
    exp_q.push_back(ex(0, 13, -8));
    exp_q.push_back(ex(1, 15, -10));
    frame(4, 4, 0, 0);
    idle();
    exp_q.push_back(ex(0, 5, 0));
    exp_q.push_back(ex(1, 7, -2));
    exp_q.push_back(ex(0, 13, -8));
    exp_q.push_back(ex(1, 15, -10));
    frame(4, 4, 0, 1);

    // Odd width: unpaired column 4 carries the big value and must never appear
    exp_q.push_back(ex(0, -5, -5));
    exp_q.push_back(ex(1, -5, -5));
    frame(5, 2, 1, 0);

    // Width below 2 yields nothing
    frame(1, 4, 0, 0);
    frame(0, 1, 0, 0);

    // Single-window frames from the table
    tbl[0] = mk(-32768, 32767, -1, 0,   -3, -7, -3, -9,   32767, -3);
    tbl[1] = mk(1, 1, 1, 1,             -1, -1, -1, -2,   1, -1);
    tbl[2] = mk(0, 0, 0, 100,           -32768, -32768, -32768, -32768,   100, -32768);
    tbl[3] = mk(7, -8, 9, -10,          32767, -32768, 32767, -32768,     9, 32767);
    tbl[4] = mk(-2, -2, -1, -3,         5, 6, 7, 8,       -1, 8);
    img_w = (ADDR_W+1)'(2);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex(1, tbl[i].e0, tbl[i].e1));
      for (int j = 0; j < 4; j++) begin
        beat(j == 0, 1'b1, {tbl[i].p1[j], tbl[i].p0[j]}, j == 3);
      end
    end

    // Reset after row 1 column 1: first window comes out, then silence until the next sof
    img_w = (ADDR_W+1)'(4);
    exp_q.push_back(ex(0, 5, 0));
    for (int k = 0; k < 6; k++) begin
      beat(k == 0, 1'b1, px(0, 4, k / 4, k % 4), k == 5);
    end
    @(negedge clk);
    resetn = 1'b1;
    en     = 1'b0;
    sof    = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_out", {32'd0, pool_out}, 64'd0);
    @(negedge clk);
    resetn = 1'b0;
    for (int k = 6; k < 16; k++) begin
      beat(1'b0, 1'b1, px(0, 4, k / 4, k % 4), 1'b0);
    end
    exp_q.push_back(ex(0, 5, 0));
    exp_q.push_back(ex(1, 7, -2));
    frame(4, 2, 0, 0);

    // sof at row 1 column 3 drops the open window; the new 2-wide frame pools correctly
    img_w = (ADDR_W+1)'(4);
    exp_q.push_back(ex(0, 5, 0));
    for (int k = 0; k < 7; k++) begin
      beat(k == 0, 1'b1, px(0, 4, k / 4, k % 4), k == 5);
    end
    img_w = (ADDR_W+1)'(2);
    exp_q.push_back(ex(1, 3, 0));
    beat(1'b1, 1'b1, px(0, 2, 0, 0), 1'b0);
    beat(1'b0, 1'b1, px(0, 2, 0, 1), 1'b0);
    beat(1'b0, 1'b1, px(0, 2, 1, 0), 1'b0);
    beat(1'b0, 1'b1, px(0, 2, 1, 1), 1'b1);
    idle();
    idle();

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
